pulse_stretcher: RTL and testbench
==================================

// Module: pulse_stretcher
// PURPOSE
//  Converts a one-clock trigger pulse into a programmable-width output level after a
//  programmable delay. Complement of the posedge pulse detector: that block turns
//  levels into 1-cycle pulses; this one turns 1-cycle pulses back into timed levels.
//  Used for strobes, LED/blink outputs, enables and retimed control lines.
// PARAMETERS
//  CNT_W    8  width of the Delay/Width inputs and of the internal down-counter
//  HOLDOFF  2  dead cycles after the level drops before a new trigger is accepted (0 = none)
// PORTS
//  Clock     in   1      system clock; all logic on posedge
//  ResetN    in   1      synchronous active-low reset
//  InPulse   in   1      trigger; every cycle it is sampled high counts as one trigger
//  Delay     in   CNT_W  cycles from trigger acceptance to level rise; sampled with the trigger
//  Width     in   CNT_W  level length in cycles; sampled with the trigger; 0 treated as 1
//  OutLevel  out  1      stretched output level (registered)
//  Busy      out  1      high from the cycle after acceptance to the end of HOLDOFF
//  Missed    out  1      1-cycle flag: a trigger arrived while Busy and was dropped
// BEHAVIOUR
//  - One clock, synchronous active-low reset: ResetN low at a posedge -> state IDLE,
//    counter 0, OutLevel=0, Busy=0, Missed=0. Applies mid-operation; an InPulse in the
//    reset cycle is ignored. All outputs registered; no combinational input->output path.
//  - States IDLE, DELAY, ACTIVE, HOLD.
//  - IDLE: InPulse=1 at edge T -> latch Delay, Width; Busy=1 from cycle T+1.
//    Delay=0 -> ACTIVE (OutLevel=1 from cycle T+1); else DELAY, counter=Delay.
//  - DELAY: counter decrements each cycle; when it reaches 0 -> ACTIVE, so OutLevel
//    rises at cycle T+1+Delay. Latency: 1+Delay cycles.
//  - ACTIVE: OutLevel=1 for exactly max(Width,1) cycles, then OutLevel=0. Next state is
//    HOLD when HOLDOFF>0, else IDLE.
//  - HOLD: HOLDOFF cycles with Busy=1, OutLevel=0; then IDLE, Busy=0. A trigger is
//    accepted on the first edge in IDLE.
//  - Back-to-back with HOLDOFF=0: a trigger at the edge where ACTIVE ends is dropped.
//    Busy is still 1 there. A trigger one cycle later is accepted.
//  - InPulse=1 while Busy (DELAY, ACTIVE or HOLD): trigger dropped; Missed=1 the next cycle.
//    A held-high InPulse gives Missed every such cycle. Missed is never set in IDLE.
//  - Counter arithmetic is unsigned CNT_W bits and never wraps. The max value
//    2^CNT_W-1 is legal for both Delay and Width.
//  - Delay/Width changes while Busy have no effect on the pulse in progress.
// CONFIGURATION
//  PULSE_STRETCH_RETRIGGER_EN defined:
//    InPulse=1 in ACTIVE reloads the counter from the current Width input.
//    OutLevel stays high continuously for Width more cycles counted from the retrigger
//    edge. Missed is not set for that trigger.
//    Triggers in DELAY or HOLD are still dropped with Missed.
//  Not defined: triggers in ACTIVE are dropped and flag Missed like any other Busy state.
// TESTING
//  1 Reset: ResetN=0 with InPulse=1 for 3 cycles -> OutLevel/Busy/Missed=0, no pulse after release
//  2 Delay=0 Width=4, trigger at T -> OutLevel=1 cycles T+1..T+4; Busy T+1..T+6 (HOLDOFF=2)
//  3 Delay=3 Width=0, trigger at T -> OutLevel=1 only at cycle T+4; Delay=255 Width=255 -> 255-cycle level, no wrap
//  4 Trigger at T+2 during test-2 pulse, macro off -> Missed=1 at T+3 only, OutLevel ends T+4
//  5 Same with PULSE_STRETCH_RETRIGGER_EN, Width=4 -> OutLevel continuous T+1..T+6, Missed stays 0
//  6 ResetN=0 at T+2 of a Width=10 pulse -> OutLevel=0 from T+3; new trigger after release -> normal pulse

Source files
------------

// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle trigger into a level of programmable width after a programmable delay.
// Optional build macro PULSE_STRETCH_RETRIGGER_EN: a trigger during the level extends it.
module pulse_stretcher #(
  parameter int CNT_W   = 8,
  parameter int HOLDOFF = 2
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             InPulse,
  input  logic [CNT_W-1:0] Delay,
  input  logic [CNT_W-1:0] Width,
  output logic             OutLevel,
  output logic             Busy,
  output logic             Missed,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_ACTIVE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLDOFF);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] width_eff;
  logic             retrig_en;

  // A requested width of zero still produces a one-cycle level.
  assign width_eff = (Width == '0) ? ONE : Width;
  assign dbg_state = state;

`ifdef PULSE_STRETCH_RETRIGGER_EN
  assign retrig_en = 1'b1;
`else
  assign retrig_en = 1'b0;
`endif

  // The counter only ever decrements from a value >= 1, so it cannot wrap.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state    <= S_IDLE;
      cnt      <= '0;
      width_q  <= '0;
      OutLevel <= 1'b0;
      Busy     <= 1'b0;
      Missed   <= 1'b0;
    end else begin
      Missed <= 1'b0;
      case (state)
        S_IDLE: begin
          if (InPulse) begin
            Busy    <= 1'b1;
            width_q <= width_eff;
            if (Delay == '0) begin
              state    <= S_ACTIVE;
              cnt      <= width_eff;
              OutLevel <= 1'b1;
            end else begin
              state <= S_DELAY;
              cnt   <= Delay;
            end
          end
        end
        S_DELAY: begin
          Missed <= InPulse;
          if (cnt == ONE) begin
            state    <= S_ACTIVE;
            cnt      <= width_q;
            OutLevel <= 1'b1;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        S_ACTIVE: begin
          if (retrig_en && InPulse) begin
            cnt <= width_eff;
          end else begin
            Missed <= InPulse;
            if (cnt == ONE) begin
              OutLevel <= 1'b0;
              if (HOLDOFF > 0) begin
                state <= S_HOLD;
                cnt   <= HOLD_CNT;
              end else begin
                state <= S_IDLE;
                cnt   <= '0;
                Busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt - ONE;
            end
          end
        end
        S_HOLD: begin
          Missed <= InPulse;
          if (cnt == ONE) begin
            state <= S_IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: table of single-trigger vectors plus hand-written
// sequences for reset, dropped triggers, retrigger and back-to-back with no hold-off.
module tb_pulse_stretcher;

  logic       Clock;
  logic       ResetN;
  logic       InPulse;
  logic [7:0] Delay;
  logic [7:0] Width;
  logic       out_level, busy, missed;
  logic       out_level0, busy0, missed0;
  logic [1:0] dbg_state, dbg_state0;

  int checks = 0;
  int errors = 0;

  pulse_stretcher #(.CNT_W(8), .HOLDOFF(2)) u_dut (
    .Clock(Clock), .ResetN(ResetN), .InPulse(InPulse), .Delay(Delay), .Width(Width),
    .OutLevel(out_level), .Busy(busy), .Missed(missed), .dbg_state(dbg_state)
  );

  pulse_stretcher #(.CNT_W(8), .HOLDOFF(0)) u_dut0 (
    .Clock(Clock), .ResetN(ResetN), .InPulse(InPulse), .Delay(Delay), .Width(Width),
    .OutLevel(out_level0), .Busy(busy0), .Missed(missed0), .dbg_state(dbg_state0)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] delay;
    logic [7:0] width;
    int         rise;   // first cycle after the trigger edge with OutLevel high (1-based)
    int         len;    // number of cycles OutLevel stays high
    int         blen;   // number of cycles Busy stays high
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Drives a one-edge trigger; returns in cycle T+1.
  task automatic trigger(input logic [7:0] d, input logic [7:0] w);
    Delay   = d;
    Width   = w;
    InPulse = 1'b1;
    step();
    InPulse = 1'b0;
  endtask

  initial begin
    vecs[0] = '{delay: 8'd0,   width: 8'd4,   rise: 1,   len: 4,   blen: 6};
    vecs[1] = '{delay: 8'd3,   width: 8'd0,   rise: 4,   len: 1,   blen: 6};
    vecs[2] = '{delay: 8'd1,   width: 8'd1,   rise: 2,   len: 1,   blen: 4};
    vecs[3] = '{delay: 8'd0,   width: 8'd0,   rise: 1,   len: 1,   blen: 3};
    vecs[4] = '{delay: 8'd5,   width: 8'd2,   rise: 6,   len: 2,   blen: 9};
    vecs[5] = '{delay: 8'd255, width: 8'd255, rise: 256, len: 255, blen: 512};

    // reset held with InPulse high: trigger ignored
    ResetN  = 1'b0;
    InPulse = 1'b1;
    Delay   = 8'd0;
    Width   = 8'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst%0d out", i), out_level, 1'b0);
      chk($sformatf("rst%0d busy", i), busy, 1'b0);
      chk($sformatf("rst%0d missed", i), missed, 1'b0);
    end
    ResetN  = 1'b1;
    InPulse = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("post_rst%0d out", i), out_level, 1'b0);
      chk($sformatf("post_rst%0d busy", i), busy, 1'b0);
    end

    // table-driven single triggers
    for (int i = 0; i < 6; i++) begin
      trigger(vecs[i].delay, vecs[i].width);
      for (int k = 1; k <= vecs[i].blen + 1; k++) begin
        chk($sformatf("vec%0d k%0d out", i, k), out_level,
            (k >= vecs[i].rise) && (k < vecs[i].rise + vecs[i].len));
        chk($sformatf("vec%0d k%0d busy", i, k), busy, k <= vecs[i].blen);
        chk($sformatf("vec%0d k%0d missed", i, k), missed, 1'b0);
        step();
      end
    end

    // trigger at T+2 of a Delay=0 Width=4 pulse
    trigger(8'd0, 8'd4);                      // cycle T+1
    step();                                   // cycle T+2
    InPulse = 1'b1;
    step();                                   // cycle T+3
    InPulse = 1'b0;
`ifdef PULSE_STRETCH_RETRIGGER_EN
    chk("retrig T+3 missed", missed, 1'b0);
    for (int k = 3; k <= 6; k++) begin
      chk($sformatf("retrig T+%0d out", k), out_level, 1'b1);
      chk($sformatf("retrig T+%0d missed", k), missed, 1'b0);
      step();
    end
    chk("retrig T+7 out", out_level, 1'b0);
`else
    chk("miss T+3 missed", missed, 1'b1);
    chk("miss T+3 out", out_level, 1'b1);
    step();                                   // cycle T+4
    chk("miss T+4 missed", missed, 1'b0);
    chk("miss T+4 out", out_level, 1'b1);
    step();                                   // cycle T+5
    chk("miss T+5 out", out_level, 1'b0);
    chk("miss T+5 busy", busy, 1'b1);
`endif
    repeat (6) step();

    // held-high InPulse during DELAY flags Missed every cycle
    trigger(8'd5, 8'd1);                      // cycle T+1
    InPulse = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      step();
      chk($sformatf("held T+%0d missed", k), missed, 1'b1);
    end
    InPulse = 1'b0;
    step();
    chk("held T+5 missed", missed, 1'b0);
    repeat (8) step();
    chk("held idle busy", busy, 1'b0);

    // Delay/Width changes while busy do not affect the pulse in progress
    trigger(8'd2, 8'd3);
    Delay = 8'd7;
    Width = 8'd9;
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("latch k%0d out", k), out_level, (k >= 3) && (k <= 5));
      step();
    end
    repeat (3) step();

    // synchronous reset mid-pulse
    trigger(8'd0, 8'd10);                     // cycle T+1
    step();                                   // cycle T+2
    chk("mid_rst T+2 out", out_level, 1'b1);
    ResetN = 1'b0;
    step();                                   // cycle T+3
    chk("mid_rst T+3 out", out_level, 1'b0);
    chk("mid_rst T+3 busy", busy, 1'b0);
    ResetN = 1'b1;
    step();
    trigger(8'd0, 8'd2);
    chk("after_rst k1 out", out_level, 1'b1);
    step();
    chk("after_rst k2 out", out_level, 1'b1);
    step();
    chk("after_rst k3 out", out_level, 1'b0);
    repeat (6) step();

    // back-to-back with no hold-off (second instance)
    trigger(8'd0, 8'd2);                      // cycle T+1
    step();                                   // cycle T+2
    chk("b2b T+2 busy0", busy0, 1'b1);
    chk("b2b T+2 out0", out_level0, 1'b1);
    InPulse = 1'b1;
    step();                                   // cycle T+3: dropped at the ending edge
    chk("b2b T+3 missed0", missed0, 1'b1);
    chk("b2b T+3 out0", out_level0, 1'b0);
    chk("b2b T+3 busy0", busy0, 1'b0);
    step();                                   // cycle T+4: accepted
    InPulse = 1'b0;
    chk("b2b T+4 out0", out_level0, 1'b1);
    chk("b2b T+4 busy0", busy0, 1'b1);
    chk("b2b T+4 missed0", missed0, 1'b0);
    repeat (8) step();
    chk("b2b end busy0", busy0, 1'b0);
    chk("b2b end busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
